// File: rtl/seg_execute_muldiv.sv
// Iterative MIPS multiply/divide unit owning HI/LO (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Optional macro MULDIV_ZERO_FAST_EN: zero operands skip the bit-serial RUN phase.
module seg_execute_muldiv #(
   parameter int NB_DATA  = 32,
   parameter int NB_MDCTL = 2,
   parameter int NB_COUNT = 6
) (
   input  logic                i_clock,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [NB_MDCTL-1:0] i_op,
   input  logic [NB_DATA-1:0]  i_data_a,
   input  logic [NB_DATA-1:0]  i_data_b,
   input  logic                i_hi_we,
   input  logic                i_lo_we,
   input  logic [NB_DATA-1:0]  i_wr_data,
   output logic [NB_DATA-1:0]  o_hi,
   output logic [NB_DATA-1:0]  o_lo,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_div_by_zero
);
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t              r_state;
   logic [NB_COUNT-1:0] r_cnt;
   logic                r_is_div;
   logic                r_neg_q;
   logic                r_neg_r;
   logic                r_bzero;
   logic [NB_DATA-1:0]  r_mag_a;
   logic [NB_DATA-1:0]  r_mag_b;
   logic [NB_DATA-1:0]  r_acc;
   logic [NB_DATA-1:0]  r_q;
   logic [NB_DATA-1:0]  r_hi;
   logic [NB_DATA-1:0]  r_lo;
   logic                r_busy;
   logic                r_done;
   logic                r_dbz;

   logic                  w_signed;
   logic                  w_a_neg;
   logic                  w_b_neg;
   logic [NB_DATA-1:0]    w_mag_a;
   logic [NB_DATA-1:0]    w_mag_b;
   logic                  w_fast;
   logic [NB_DATA:0]      w_sum;
   logic [NB_DATA:0]      w_shift;
   logic                  w_ge;
   logic [NB_DATA-1:0]    w_sub;
   logic [2*NB_DATA-1:0]  w_prod;
   logic [2*NB_DATA-1:0]  w_prod_fix;

   assign w_signed = ~i_op[0];
   assign w_a_neg  = w_signed & i_data_a[NB_DATA-1];
   assign w_b_neg  = w_signed & i_data_b[NB_DATA-1];
   assign w_mag_a  = w_a_neg ? -i_data_a : i_data_a;
   assign w_mag_b  = w_b_neg ? -i_data_b : i_data_b;

`ifdef MULDIV_ZERO_FAST_EN
   assign w_fast = (i_data_b == '0) | (~i_op[1] & (i_data_a == '0));
`else
   assign w_fast = 1'b0;
`endif

   // Shift-add multiply step: conditional add, then shift {carry, acc, q} right.
   assign w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_mag_a} : '0);
   // Restoring divide step: bring in the dividend MSB, subtract if it fits.
   assign w_shift = {r_acc, r_q[NB_DATA-1]};
   assign w_ge    = (w_shift >= {1'b0, r_mag_b});
   assign w_sub   = w_shift[NB_DATA-1:0] - r_mag_b;

   assign w_prod     = {r_acc, r_q};
   assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_bzero  <= 1'b0;
         r_mag_a  <= '0;
         r_mag_b  <= '0;
         r_acc    <= '0;
         r_q      <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dbz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_dbz  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_hi_we) r_hi <= i_wr_data;
               if (i_lo_we) r_lo <= i_wr_data;
               if (i_start) begin
                  r_is_div <= i_op[1];
                  r_neg_q  <= w_a_neg ^ w_b_neg;
                  r_neg_r  <= w_a_neg;
                  r_bzero  <= i_op[1] & (i_data_b == '0);
                  r_mag_a  <= w_mag_a;
                  r_mag_b  <= w_mag_b;
                  r_acc    <= '0;
                  r_q      <= i_op[1] ? w_mag_a : ((w_fast) ? '0 : w_mag_b);
                  r_cnt    <= '0;
                  r_busy   <= 1'b1;
                  r_state  <= w_fast ? ST_DONE : ST_RUN;
               end
            end
            ST_RUN: begin
               if (r_is_div) begin
                  r_acc <= w_ge ? w_sub : w_shift[NB_DATA-1:0];
                  r_q   <= {r_q[NB_DATA-2:0], w_ge};
               end else begin
                  r_acc <= w_sum[NB_DATA:1];
                  r_q   <= {w_sum[0], r_q[NB_DATA-1:1]};
               end
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == NB_COUNT'(NB_DATA-1)) r_state <= ST_DONE;
            end
            ST_DONE: begin
               if (!r_is_div) begin
                  {r_hi, r_lo} <= w_prod_fix;
               end else if (r_bzero) begin
                  // Divide by zero returns the dividend as latched in HI.
                  r_hi  <= r_neg_r ? -r_mag_a : r_mag_a;
                  r_lo  <= '1;
                  r_dbz <= 1'b1;
               end else begin
                  r_lo <= r_neg_q ? -r_q : r_q;
                  r_hi <= r_neg_r ? -r_acc : r_acc;
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_hi          = r_hi;
   assign o_lo          = r_lo;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_div_by_zero = r_dbz;
endmodule

// File: tb/tb_seg_execute_muldiv.sv
// Directed self-checking bench for seg_execute_muldiv (honours MULDIV_ZERO_FAST_EN for latency).
module tb_seg_execute_muldiv;
   logic        i_clock = 1'b0;
   logic        i_reset, i_start, i_hi_we, i_lo_we;
   logic [1:0]  i_op;
   logic [31:0] i_data_a, i_data_b, i_wr_data;
   logic [31:0] o_hi, o_lo;
   logic        o_busy, o_done, o_div_by_zero;

   int n_checks = 0;
   int n_errors = 0;

   localparam int EXP_LAT = 33;
`ifdef MULDIV_ZERO_FAST_EN
   localparam int ZERO_LAT = 1;
`else
   localparam int ZERO_LAT = 33;
`endif

   seg_execute_muldiv dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start), .i_op(i_op),
      .i_data_a(i_data_a), .i_data_b(i_data_b), .i_hi_we(i_hi_we), .i_lo_we(i_lo_we),
      .i_wr_data(i_wr_data), .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy),
      .o_done(o_done), .o_div_by_zero(o_div_by_zero)
   );

   always #5 i_clock = ~i_clock;

   // Called 1 time unit after an edge; returns in the o_done cycle (or after timeout, lat=-1).
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cyc, output logic dbz);
      i_op = op; i_data_a = a; i_data_b = b; i_start = 1'b1;
      @(posedge i_clock); #1;
      i_start = 1'b0;
      lat = -1; busy_cyc = 0; dbz = 1'b0;
      for (int k = 1; k <= 100 && lat < 0; k++) begin
         if (o_busy) busy_cyc++;
         @(posedge i_clock); #1;
         if (o_done) begin lat = k; dbz = o_div_by_zero; end
      end
   endtask

   task automatic test_reset();
      i_reset = 1'b1;
      repeat (3) @(posedge i_clock);
      #1;
      n_checks++; if (o_hi !== 32'h0) begin n_errors++; $display("FAIL reset_hi: got %h exp %h", o_hi, 32'h0); end
      n_checks++; if (o_lo !== 32'h0) begin n_errors++; $display("FAIL reset_lo: got %h exp %h", o_lo, 32'h0); end
      n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", o_busy); end
      n_checks++; if (o_done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b exp 0", o_done); end
      n_checks++; if (o_div_by_zero !== 1'b0) begin n_errors++; $display("FAIL reset_dbz: got %b exp 0", o_div_by_zero); end
      i_reset = 1'b0;
   endtask

   task automatic test_mt_and_ignore();
      int lat;
      i_hi_we = 1'b1; i_wr_data = 32'h1234;
      @(posedge i_clock); #1;
      i_hi_we = 1'b0;
      n_checks++; if (o_hi !== 32'h1234) begin n_errors++; $display("FAIL mthi: got %h exp %h", o_hi, 32'h1234); end
      i_op = 2'b01; i_data_a = 32'd6; i_data_b = 32'd7; i_start = 1'b1;
      @(posedge i_clock); #1;
      i_start = 1'b0;
      repeat (5) @(posedge i_clock);
      #1;
      i_start = 1'b1; i_op = 2'b10; i_data_a = 32'd99; i_data_b = 32'd3;
      i_lo_we = 1'b1; i_wr_data = 32'hAAAA;
      @(posedge i_clock); #1;
      i_start = 1'b0; i_lo_we = 1'b0;
      n_checks++; if (o_lo !== 32'h0) begin n_errors++; $display("FAIL mtlo_busy_drop: got %h exp %h", o_lo, 32'h0); end
      n_checks++; if (o_hi !== 32'h1234) begin n_errors++; $display("FAIL hi_stable_run: got %h exp %h", o_hi, 32'h1234); end
      lat = -1;
      for (int k = 7; k <= 100 && lat < 0; k++) begin
         @(posedge i_clock); #1;
         if (o_done) lat = k;
      end
      n_checks++; if (lat !== EXP_LAT) begin n_errors++; $display("FAIL ign_lat: got %0d exp %0d", lat, EXP_LAT); end
      n_checks++; if (o_hi !== 32'h0) begin n_errors++; $display("FAIL ign_hi: got %h exp %h", o_hi, 32'h0); end
      n_checks++; if (o_lo !== 32'd42) begin n_errors++; $display("FAIL ign_lo: got %h exp %h", o_lo, 32'd42); end
      @(posedge i_clock); #1;
      n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL ign_no_queue: got %b exp 0", o_busy); end
   endtask

   task automatic test_mt_with_start();
      int lat, bc; logic dz;
      i_lo_we = 1'b1; i_wr_data = 32'h55;
      i_op = 2'b01; i_data_a = 32'd2; i_data_b = 32'd3; i_start = 1'b1;
      @(posedge i_clock); #1;
      i_lo_we = 1'b0; i_start = 1'b0;
      n_checks++; if (o_lo !== 32'h55) begin n_errors++; $display("FAIL mtlo_at_e0: got %h exp %h", o_lo, 32'h55); end
      n_checks++; if (o_busy !== 1'b1) begin n_errors++; $display("FAIL start_with_mt_busy: got %b exp 1", o_busy); end
      lat = -1;
      for (int k = 1; k <= 100 && lat < 0; k++) begin
         @(posedge i_clock); #1;
         if (o_done) lat = k;
      end
      n_checks++; if (o_lo !== 32'd6) begin n_errors++; $display("FAIL mt_start_lo: got %h exp %h", o_lo, 32'd6); end
      bc = 0; dz = 1'b0;
   endtask

   task automatic test_mult();
      int lat, bc; logic dz;
      run_op(2'b00, 32'hFFFFFFFD, 32'd5, lat, bc, dz);
      n_checks++; if (lat !== EXP_LAT) begin n_errors++; $display("FAIL mult_lat: got %0d exp %0d", lat, EXP_LAT); end
      n_checks++; if (bc !== 33) begin n_errors++; $display("FAIL mult_busy_cycles: got %0d exp 33", bc); end
      n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL mult_busy_at_done: got %b exp 0", o_busy); end
      n_checks++; if (o_hi !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL mult_hi: got %h exp %h", o_hi, 32'hFFFFFFFF); end
      n_checks++; if (o_lo !== 32'hFFFFFFF1) begin n_errors++; $display("FAIL mult_lo: got %h exp %h", o_lo, 32'hFFFFFFF1); end
      n_checks++; if (dz !== 1'b0) begin n_errors++; $display("FAIL mult_dbz: got %b exp 0", dz); end
      @(posedge i_clock); #1;
      n_checks++; if (o_done !== 1'b0) begin n_errors++; $display("FAIL mult_done_pulse: got %b exp 0", o_done); end
      run_op(2'b00, 32'h0, 32'd5, lat, bc, dz);
      n_checks++; if (lat !== ZERO_LAT) begin n_errors++; $display("FAIL mult_zero_lat: got %0d exp %0d", lat, ZERO_LAT); end
      n_checks++; if ({o_hi, o_lo} !== 64'h0) begin n_errors++; $display("FAIL mult_zero_res: got %h exp 0", {o_hi, o_lo}); end
   endtask

   task automatic test_multu_back_to_back();
      int lat, bc; logic dz;
      run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, dz);
      n_checks++; if (o_hi !== 32'hFFFFFFFE) begin n_errors++; $display("FAIL multu_hi: got %h exp %h", o_hi, 32'hFFFFFFFE); end
      n_checks++; if (o_lo !== 32'h00000001) begin n_errors++; $display("FAIL multu_lo: got %h exp %h", o_lo, 32'h1); end
      // Start issued in the o_done cycle must be accepted.
      run_op(2'b11, 32'd1000, 32'd3, lat, bc, dz);
      n_checks++; if (lat !== EXP_LAT) begin n_errors++; $display("FAIL b2b_lat: got %0d exp %0d", lat, EXP_LAT); end
      n_checks++; if (o_lo !== 32'd333) begin n_errors++; $display("FAIL b2b_lo: got %h exp %h", o_lo, 32'd333); end
      n_checks++; if (o_hi !== 32'd1) begin n_errors++; $display("FAIL b2b_hi: got %h exp %h", o_hi, 32'd1); end
   endtask

   task automatic test_div();
      int lat, bc; logic dz;
      run_op(2'b10, 32'hFFFFFFF9, 32'd2, lat, bc, dz);
      n_checks++; if (o_lo !== 32'hFFFFFFFD) begin n_errors++; $display("FAIL div_neg_lo: got %h exp %h", o_lo, 32'hFFFFFFFD); end
      n_checks++; if (o_hi !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL div_neg_hi: got %h exp %h", o_hi, 32'hFFFFFFFF); end
      run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, lat, bc, dz);
      n_checks++; if (o_lo !== 32'h80000000) begin n_errors++; $display("FAIL div_ovf_lo: got %h exp %h", o_lo, 32'h80000000); end
      n_checks++; if (o_hi !== 32'h0) begin n_errors++; $display("FAIL div_ovf_hi: got %h exp %h", o_hi, 32'h0); end
      run_op(2'b10, 32'd7, 32'hFFFFFFFE, lat, bc, dz);
      n_checks++; if (o_lo !== 32'hFFFFFFFD) begin n_errors++; $display("FAIL div_negb_lo: got %h exp %h", o_lo, 32'hFFFFFFFD); end
      n_checks++; if (o_hi !== 32'd1) begin n_errors++; $display("FAIL div_negb_hi: got %h exp %h", o_hi, 32'd1); end
      run_op(2'b11, 32'hFFFFFFF9, 32'd2, lat, bc, dz);
      n_checks++; if (o_lo !== 32'h7FFFFFFC) begin n_errors++; $display("FAIL divu_lo: got %h exp %h", o_lo, 32'h7FFFFFFC); end
      n_checks++; if (o_hi !== 32'd1) begin n_errors++; $display("FAIL divu_hi: got %h exp %h", o_hi, 32'd1); end
   endtask

   task automatic test_div_zero();
      int lat, bc; logic dz;
      run_op(2'b11, 32'd100, 32'd0, lat, bc, dz);
      n_checks++; if (lat !== ZERO_LAT) begin n_errors++; $display("FAIL dbz_lat: got %0d exp %0d", lat, ZERO_LAT); end
      n_checks++; if (dz !== 1'b1) begin n_errors++; $display("FAIL dbz_flag: got %b exp 1", dz); end
      n_checks++; if (o_hi !== 32'd100) begin n_errors++; $display("FAIL dbz_hi: got %h exp %h", o_hi, 32'd100); end
      n_checks++; if (o_lo !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL dbz_lo: got %h exp %h", o_lo, 32'hFFFFFFFF); end
      @(posedge i_clock); #1;
      n_checks++; if (o_div_by_zero !== 1'b0) begin n_errors++; $display("FAIL dbz_pulse: got %b exp 0", o_div_by_zero); end
      run_op(2'b10, 32'hFFFFFFF8, 32'd0, lat, bc, dz);
      n_checks++; if (o_hi !== 32'hFFFFFFF8) begin n_errors++; $display("FAIL dbz_s_hi: got %h exp %h", o_hi, 32'hFFFFFFF8); end
      n_checks++; if (dz !== 1'b1) begin n_errors++; $display("FAIL dbz_s_flag: got %b exp 1", dz); end
   endtask

   task automatic test_reset_mid();
      int lat, bc, dones; logic dz;
      i_op = 2'b11; i_data_a = 32'd1000; i_data_b = 32'd3; i_start = 1'b1;
      @(posedge i_clock); #1;
      i_start = 1'b0;
      repeat (9) @(posedge i_clock);
      #1;
      i_reset = 1'b1;
      @(posedge i_clock); #1;
      i_reset = 1'b0;
      n_checks++; if (o_busy !== 1'b0) begin n_errors++; $display("FAIL rmid_busy: got %b exp 0", o_busy); end
      n_checks++; if ({o_hi, o_lo} !== 64'h0) begin n_errors++; $display("FAIL rmid_hilo: got %h exp 0", {o_hi, o_lo}); end
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         if (o_done) dones++;
         @(posedge i_clock); #1;
      end
      n_checks++; if (dones !== 0) begin n_errors++; $display("FAIL rmid_no_done: got %0d exp 0", dones); end
      run_op(2'b11, 32'd1000, 32'd3, lat, bc, dz);
      n_checks++; if (lat !== EXP_LAT) begin n_errors++; $display("FAIL rmid_new_lat: got %0d exp %0d", lat, EXP_LAT); end
      n_checks++; if (o_lo !== 32'd333) begin n_errors++; $display("FAIL rmid_new_lo: got %h exp %h", o_lo, 32'd333); end
      n_checks++; if (o_hi !== 32'd1) begin n_errors++; $display("FAIL rmid_new_hi: got %h exp %h", o_hi, 32'd1); end
   endtask

   initial begin
      i_reset = 1'b0; i_start = 1'b0; i_hi_we = 1'b0; i_lo_we = 1'b0;
      i_op = 2'b00; i_data_a = '0; i_data_b = '0; i_wr_data = '0;
      test_reset();
      test_mt_and_ignore();
      test_mt_with_start();
      test_mult();
      test_multu_back_to_back();
      test_div();
      test_div_zero();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/seg_execute_muldiv.md
Name: seg_execute_muldiv

Overview:
- Iterative multiply/divide unit for the MIPS execute stage; covers MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Owns the architectural HI/LO registers and drives them directly to the MFHI/MFLO path.
- Sits beside the single-cycle execute ALU. While an operation runs, it asserts a stall request toward the hazard unit.

Parameters:
- NB_DATA, 32, operand and HI/LO width.
- NB_MDCTL, 2, operation select width.
- NB_COUNT, 6, iteration counter width; must satisfy 2^NB_COUNT > NB_DATA.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  launch operation selected by i_op (sampled only in IDLE).
- i_op  in  NB_MDCTL  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- i_data_a  in  NB_DATA  rs: multiplicand or dividend.
- i_data_b  in  NB_DATA  rt: multiplier or divisor.
- i_hi_we  in  1  MTHI write enable.
- i_lo_we  in  1  MTLO write enable.
- i_wr_data  in  NB_DATA  MTHI/MTLO data.
- o_hi  out  NB_DATA  HI register.
- o_lo  out  NB_DATA  LO register.
- o_busy  out  1  operation in progress; pipeline stall request.
- o_done  out  1  one-cycle pulse; HI/LO hold the new result.
- o_div_by_zero  out  1  pulses with o_done when a DIV/DIVU had divisor 0.

Behaviour:
- Single clock i_clock; reset i_reset is synchronous, active-high.
- Reset (any state, including mid-operation):
  - state=IDLE, o_hi=0, o_lo=0, o_busy=0, o_done=0, o_div_by_zero=0.
  - Operation in flight is discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE, i_start=1 (edge E0): latch operand magnitudes, result-sign flags and op; counter=0; go to RUN.
  - RUN: one bit step per edge (E1..E_NB_DATA). Multiply is shift-add; divide is restoring. At E_NB_DATA, go to DONE.
  - DONE, edge E_NB_DATA+1: apply sign fixup, write HI/LO, register o_done=1 (and o_div_by_zero if applicable), go to IDLE.
- Timing and handshake:
  - o_busy = (state != IDLE), registered. It is high in the cycles following E0..E_NB_DATA.
  - o_done is high only in the cycle after E_NB_DATA+1. o_busy is already low in that cycle.
  - A new i_start in that same cycle is accepted (back-to-back ops).
  - Default latency: NB_DATA+2 cycles from start sample to o_done.
- i_start while not IDLE: ignored; no queueing.
- Multiply results: HI:LO = 2*NB_DATA-bit product.
  - MULT: signed; product negated if operand signs differ.
  - MULTU: unsigned.
- Divide results: LO=quotient, HI=remainder.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned.
- Divide boundary cases:
  - DIV with a=0x80000000, b=0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divisor 0 (DIV or DIVU): HI=i_data_a as latched, LO=all ones, o_div_by_zero=1 with o_done.
- MTHI/MTLO:
  - Writes take effect at the edge only when the state is IDLE.
  - Writes presented while o_busy=1 or in DONE are dropped; the result always wins.
  - i_start with i_hi_we or i_lo_we in the same IDLE cycle: the MT write lands at E0, and the operation overwrites HI/LO later.
- HI/LO are stable except at reset, an IDLE MT write, or the DONE edge.
- Operands are latched at E0; input changes during RUN have no effect.

Optional Feature:
- Macro: MULDIV_ZERO_FAST_EN.
- Defined:
  - At E0, if i_data_b==0, or i_data_a==0 for MULT/MULTU, the FSM goes IDLE→DONE directly and skips RUN.
  - o_done is high in the cycle after E1 (latency 2).
  - Results are identical to the full path, including the divide-by-zero values and flag.
- Undefined:
  - Every operation takes NB_DATA+2 cycles; no zero-detect logic is synthesized.

Test Plan:
- MULT a=0xFFFFFFFD(-3), b=5 -> o_done in the cycle after E33; HI=0xFFFFFFFF, LO=0xFFFFFFF1; o_busy high for 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9(-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=100, b=0 -> HI=100, LO=0xFFFFFFFF, o_div_by_zero=1 for one cycle. With MULDIV_ZERO_FAST_EN, o_done comes 2 cycles after start.
- Sequence: MTHI 0x1234 in IDLE -> o_hi=0x1234. Start MULTU 6*7, then during RUN pulse i_start (DIV) and i_lo_we=0xAAAA -> both ignored; final HI=0, LO=42.
- Start DIVU 1000/3, assert i_reset at E10 -> next cycle o_busy=0, HI=LO=0, no o_done pulse. A new DIVU 1000/3 then completes with LO=333, HI=1.
